id_issue_ctrl: RTL and testbench
================================

Name: id_issue_ctrl

Overview:
- Issue/stall controller for the decode stage; sits between `id` and the ID/EX pipeline register.
- Keeps a per-register scoreboard of in-flight writes (`wreg_o`/`wd_o` issued, not yet written back).
- Stalls the decoded instruction while any source register it reads (`reg1_read`/`reg2_read`) has a pending write.
- Provides a drain handshake that empties the pipeline of register writes on request.

Parameters:
- ADDR_W, 4: register address width (16 architectural registers).
- NUM_REGS, 16: tracked registers; equals 2**ADDR_W.
- CNT_W, 2: per-register pending-write counter width; counter max is 2**CNT_W-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_reg1_read  in  1  instruction reads register port 1.
- id_reg1_addr  in  ADDR_W  port 1 address.
- id_reg2_read  in  1  instruction reads register port 2.
- id_reg2_addr  in  ADDR_W  port 2 address.
- id_wreg  in  1  instruction writes a register.
- id_wd  in  ADDR_W  destination register.
- ex_ready  in  1  EX stage accepts an instruction this cycle.
- wb_wreg  in  1  writeback commits a register write this cycle.
- wb_wd  in  ADDR_W  writeback destination.
- drain_req  in  1  level request to stop issue and empty the scoreboard.
- issue_o  out  1  instruction transfers ID->EX this cycle.
- stall_o  out  1  hold PC and IF/ID register.
- drain_ack  out  1  level: drained and holding.
- busy_o  out  1  any pending counter non-zero.
- err_o  out  1  sticky: writeback to a register with zero pending count.

Behaviour:
- Reset (async, rst_n=0): all counters 0, FSM=RUN, err_o=0. Outputs during reset: issue_o=0, stall_o=0, drain_ack=0, busy_o=0.
- Hazard (combinational, from registered counters only):
  - RAW when (id_reg1_read & cnt[id_reg1_addr]!=0) | (id_reg2_read & cnt[id_reg2_addr]!=0).
  - WAW-overflow when id_wreg & cnt[id_wd]==max.
  - A writeback in the same cycle does NOT clear a hazard. The regfile writes on the edge, so a same-cycle read returns the old value.
- issue_o = id_valid & ex_ready & ~hazard & (FSM==RUN).
- stall_o = id_valid & ~issue_o.
- Output latency: issue_o and stall_o are combinational (0 cycles). The counter update is visible the next cycle.
- Counter update per register r, each cycle:
  - +1 if issue_o & id_wreg & id_wd==r.
  - -1 if wb_wreg & wb_wd==r & cnt[r]!=0.
  - Both at once: unchanged.
  - wb_wreg to r with cnt[r]==0: counter stays 0 and err_o is set (sticky until reset).
- No register is exempt; register 0 is tracked like any other.
- busy_o = OR of (cnt[r]!=0), registered-state based.
- FSM:
  - RUN -> DRAIN when drain_req=1. An instruction issuing in that same cycle is allowed; the transition applies from the next cycle.
  - DRAIN: issue suppressed. -> HOLD when all counters are 0.
  - HOLD: drain_ack=1, issue suppressed. -> RUN when drain_req=0.
  - drain_req dropping while in DRAIN: -> RUN without entering HOLD.
  - drain_ack=0 in all states except HOLD.
- Reset asserted mid-drain or with writes pending: everything clears immediately. Any later writeback is flagged by err_o (the bench must not do this).

Optional Feature:
- Macro: ISSUE_CTRL_STALL_CNT_EN.
- Defined: adds output stall_cnt_o (16 bits).
  - Increments on every cycle with stall_o=1 and saturates at 16'hFFFF.
  - Cleared by reset or by the input stall_cnt_clr (1 bit); clear wins over increment.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Write then read: issue ORI r3 (id_wreg=1, id_wd=3, ex_ready=1), next cycle read r3 on port 1 -> stall_o=1, issue_o=0. Pulse wb_wreg with wb_wd=3 -> stall_o=0 and issue_o=1 in the cycle after the writeback edge, not in the writeback cycle.
- Independent registers: write r5 pending, read r6 on port 2 -> issue_o=1, stall_o=0. busy_o=1 until r5 is written back.
- Counter saturation (CNT_W=2): issue 3 writes to r7 with no writeback -> 4th write to r7 stalls. Retire one writeback to r7 -> next write issues.
- Simultaneous issue and retire to r2 with cnt=1 -> cnt stays 1. Two further writebacks to r2 -> cnt=0, then err_o=1 and held.
- Drain: 2 writes pending, raise drain_req -> issue_o=0 from the next cycle and drain_ack=0. After 2 writebacks -> drain_ack=1. Drop drain_req -> FSM returns to RUN and issue resumes.
- Async reset with cnt[4]=2, mid-DRAIN: drop rst_n between clock edges -> busy_o=0, stall_o=0, drain_ack=0 immediately. With the macro defined, stall_cnt_o=0.

Source files
------------

// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: decode-stage issue/stall control with a per-register pending-write scoreboard and drain handshake.
// Optional stall cycle counter (stall_cnt_o, stall_cnt_clr) is built when ISSUE_CTRL_STALL_CNT_EN is defined.
module id_issue_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_reg1_read,
    input  logic [ADDR_W-1:0] id_reg1_addr,
    input  logic              id_reg2_read,
    input  logic [ADDR_W-1:0] id_reg2_addr,
    input  logic              id_wreg,
    input  logic [ADDR_W-1:0] id_wd,
    input  logic              ex_ready,
    input  logic              wb_wreg,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              drain_req,
`ifdef ISSUE_CTRL_STALL_CNT_EN
    input  logic              stall_cnt_clr,
    output logic [15:0]       stall_cnt_o,
`endif
    output logic              issue_o,
    output logic              stall_o,
    output logic              drain_ack,
    output logic              busy_o,
    output logic              err_o
);
    typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t              r_state;
    logic                r_drain_ack;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic                w_busy;
    logic                w_hazard;
    // Hazards look only at registered counts: a same-cycle writeback has not reached the regfile yet.
    assign w_hazard = (id_reg1_read && r_cnt[id_reg1_addr] != '0)
                    || (id_reg2_read && r_cnt[id_reg2_addr] != '0)
                    || (id_wreg && r_cnt[id_wd] == CNT_MAX);
    assign issue_o   = rst_n && id_valid && ex_ready && !w_hazard && r_state == RUN;
    assign stall_o   = rst_n && id_valid && !issue_o;
    assign drain_ack = r_drain_ack;
    assign busy_o    = w_busy;
    assign err_o     = r_err;
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        w_busy = 1'b0;
        w_inc[id_wd] = issue_o && id_wreg;
        w_dec[wb_wd] = wb_wreg && r_cnt[wb_wd] != '0;
        for (int r = 0; r < NUM_REGS; r++) w_busy = w_busy | (r_cnt[r] != '0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
            r_err <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_inc[r] && !w_dec[r]) r_cnt[r] <= r_cnt[r] + 1'b1;
                else if (w_dec[r] && !w_inc[r]) r_cnt[r] <= r_cnt[r] - 1'b1;
            end
            if (wb_wreg && r_cnt[wb_wd] == '0) r_err <= 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_drain_ack <= 1'b0;
        end else begin
            case (r_state)
                RUN: if (drain_req) r_state <= DRAIN;
                DRAIN: begin
                    if (!drain_req) r_state <= RUN;
                    else if (!w_busy) begin
                        r_state     <= HOLD;
                        r_drain_ack <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!drain_req) begin
                        r_state     <= RUN;
                        r_drain_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= RUN;
                    r_drain_ack <= 1'b0;
                end
            endcase
        end
    end
`ifdef ISSUE_CTRL_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    assign stall_cnt_o = r_stall_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stall_cnt <= '0;
        else if (stall_cnt_clr) r_stall_cnt <= '0;
        else if (stall_o && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb_id_issue_ctrl: directed table of per-cycle vectors plus a hand sequence for async reset mid-drain.
module tb_id_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0, id_reg1_read = 1'b0, id_reg2_read = 1'b0, id_wreg = 1'b0;
    logic [3:0] id_reg1_addr = '0, id_reg2_addr = '0, id_wd = '0, wb_wd = '0;
    logic       ex_ready = 1'b0, wb_wreg = 1'b0, drain_req = 1'b0;
    logic       issue_o, stall_o, drain_ack, busy_o, err_o;
    int         checks = 0;
    int         failures = 0;
`ifdef ISSUE_CTRL_STALL_CNT_EN
    logic        stall_cnt_clr = 1'b0;
    logic [15:0] stall_cnt_o;
    int          exp_stalls = 0;
`endif

    id_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_reg1_read(id_reg1_read), .id_reg1_addr(id_reg1_addr),
        .id_reg2_read(id_reg2_read), .id_reg2_addr(id_reg2_addr),
        .id_wreg(id_wreg), .id_wd(id_wd), .ex_ready(ex_ready),
        .wb_wreg(wb_wreg), .wb_wd(wb_wd), .drain_req(drain_req),
`ifdef ISSUE_CTRL_STALL_CNT_EN
        .stall_cnt_clr(stall_cnt_clr), .stall_cnt_o(stall_cnt_o),
`endif
        .issue_o(issue_o), .stall_o(stall_o), .drain_ack(drain_ack),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vl, r1r, r2r, wr, exr, wbw, drq;
        logic [3:0] r1a, r2a, wd, wbd;
        logic [4:0] exp;  // {issue, stall, drain_ack, busy, err}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic vl, r1r, input logic [3:0] r1a, input logic r2r,
                                input logic [3:0] r2a, input logic wr, input logic [3:0] wd,
                                input logic exr, wbw, input logic [3:0] wbd, input logic drq,
                                input logic [4:0] exp);
        vec_t v;
        v.vl = vl; v.r1r = r1r; v.r1a = r1a; v.r2r = r2r; v.r2a = r2a; v.wr = wr; v.wd = wd;
        v.exr = exr; v.wbw = wbw; v.wbd = wbd; v.drq = drq; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        id_valid = v.vl; id_reg1_read = v.r1r; id_reg1_addr = v.r1a;
        id_reg2_read = v.r2r; id_reg2_addr = v.r2a; id_wreg = v.wr; id_wd = v.wd;
        ex_ready = v.exr; wb_wreg = v.wbw; wb_wd = v.wbd; drain_req = v.drq;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_reg1_read = 0; id_reg2_read = 0; id_wreg = 0;
        ex_ready = 0; wb_wreg = 0; drain_req = 0;
    endtask

    initial begin
        //              vl r1r r1a r2r r2a wr wd exr wbw wbd drq  {iss,stl,ack,bsy,err}
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 5'b00000)); // 0 idle
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 3,  1, 0, 0,  0, 5'b10000)); // 1 write r3
        tbl.push_back(mk(1, 1, 3,  0, 0,  0, 0,  1, 0, 0,  0, 5'b01010)); // 2 read r3 RAW
        tbl.push_back(mk(1, 1, 3,  0, 0,  0, 0,  1, 1, 3,  0, 5'b01010)); // 3 same-cycle wb still stalls
        tbl.push_back(mk(1, 1, 3,  0, 0,  0, 0,  1, 0, 0,  0, 5'b10000)); // 4 issues after wb edge
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 5,  1, 0, 0,  0, 5'b10000)); // 5 write r5
        tbl.push_back(mk(1, 0, 5,  1, 6,  0, 0,  1, 0, 0,  0, 5'b10010)); // 6 read r6, r5 addr unread
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 5,  0, 5'b00010)); // 7 wb r5
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 5'b00000)); // 8
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 5'b01000)); // 9 ex not ready
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 7,  1, 0, 0,  0, 5'b10000)); // 10 r7 -> 1
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 7,  1, 0, 0,  0, 5'b10010)); // 11 r7 -> 2
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 7,  1, 0, 0,  0, 5'b10010)); // 12 r7 -> 3
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 7,  1, 0, 0,  0, 5'b01010)); // 13 saturated
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 7,  1, 1, 7,  0, 5'b01010)); // 14 still stalled, r7 -> 2
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 7,  1, 0, 0,  0, 5'b10010)); // 15 issues, r7 -> 3
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 7,  0, 5'b00010)); // 16
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 7,  0, 5'b00010)); // 17
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 7,  0, 5'b00010)); // 18 r7 -> 0
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 5'b00000)); // 19
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 1,  1, 0, 0,  0, 5'b10000)); // 20 write r1
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 9,  1, 0, 0,  0, 5'b10010)); // 21 write r9
        tbl.push_back(mk(1, 0, 0,  0, 0,  1,10,  1, 0, 0,  1, 5'b10010)); // 22 drain req, issue allowed
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 1, 1,  1, 5'b01010)); // 23 DRAIN
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 1, 9,  1, 5'b01010)); // 24
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 1,10,  1, 5'b01010)); // 25 last wb
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 0, 0,  1, 5'b01000)); // 26 empty, still DRAIN
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 0, 0,  1, 5'b01100)); // 27 HOLD
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 0, 0,  0, 5'b01100)); // 28 drop req
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 0, 0,  0, 5'b10000)); // 29 RUN
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 4,  1, 0, 0,  0, 5'b10000)); // 30 write r4
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  1, 5'b00010)); // 31 drain req
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 0, 0,  1, 5'b01010)); // 32 DRAIN
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 0, 0,  0, 5'b01010)); // 33 abort drain
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 1, 4,  0, 5'b10010)); // 34 RUN, no HOLD
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 0,  1, 0, 0,  0, 5'b10000)); // 35 write r0
        tbl.push_back(mk(1, 0, 0,  1, 0,  0, 0,  1, 1, 0,  0, 5'b01010)); // 36 r0 tracked
        tbl.push_back(mk(1, 0, 0,  1, 0,  0, 0,  1, 0, 0,  0, 5'b10000)); // 37
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 2,  1, 0, 0,  0, 5'b10000)); // 38 r2 -> 1
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 2,  1, 1, 2,  0, 5'b10010)); // 39 issue+retire, stays 1
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 2,  0, 5'b00010)); // 40 r2 -> 0
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 2,  0, 5'b00000)); // 41 wb with zero count
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 5'b00001)); // 42 err sticky
        tbl.push_back(mk(1, 0, 0,  0, 0,  1, 2,  1, 0, 0,  0, 5'b10001)); // 43

        id_valid = 1; ex_ready = 1;
        #2;
        chk("rst_issue", issue_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_ack", drain_ack, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        idle_inputs();
        @(negedge clk) rst_n = 1;

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            #2;
            chk($sformatf("v%0d_issue", i), issue_o,   tbl[i].exp[4]);
            chk($sformatf("v%0d_stall", i), stall_o,   tbl[i].exp[3]);
            chk($sformatf("v%0d_ack", i),   drain_ack, tbl[i].exp[2]);
            chk($sformatf("v%0d_busy", i),  busy_o,    tbl[i].exp[1]);
            chk($sformatf("v%0d_err", i),   err_o,     tbl[i].exp[0]);
`ifdef ISSUE_CTRL_STALL_CNT_EN
            if (tbl[i].exp[3]) exp_stalls++;
`endif
        end
        @(negedge clk);
        idle_inputs();
`ifdef ISSUE_CTRL_STALL_CNT_EN
        #1 chk("stall_cnt", stall_cnt_o, 16'(exp_stalls));
`endif

        // Async reset mid-drain with r4 holding two pending writes.
        #1 rst_n = 0;
        #1 chk("rst2_err", err_o, 0);
        @(negedge clk) rst_n = 1;
        id_valid = 1; id_wreg = 1; id_wd = 4; ex_ready = 1;
        #2 chk("r4_w1_issue", issue_o, 1);
        @(negedge clk);
        #2 chk("r4_w2_issue", issue_o, 1);
        @(negedge clk);
        id_valid = 0; id_wreg = 0; drain_req = 1;
        #2 chk("r4_busy", busy_o, 1);
        @(negedge clk);
        id_valid = 1;
        #1 chk("drain_stall", stall_o, 1);
        chk("drain_issue", issue_o, 0);
        #1 rst_n = 0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_stall", stall_o, 0);
        chk("arst_ack", drain_ack, 0);
        chk("arst_issue", issue_o, 0);
`ifdef ISSUE_CTRL_STALL_CNT_EN
        chk("arst_stall_cnt", stall_cnt_o, 0);
`endif
        @(negedge clk);
        rst_n = 1; drain_req = 0;
        #2;
        chk("post_issue", issue_o, 1);
        chk("post_busy", busy_o, 0);
        chk("post_err", err_o, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
